// File: rtl/counter_sequencer.sv
// counter_sequencer: run-control FSM that enables, clears and watches an external up-counter.
// Ports:
//   clock, rst (async, active-low)
//   start/stop/pause           run control (stop > start > pause > terminal)
//   cfg_term/cfg_reps/cfg_auto configuration, latched when a start is accepted
//   cnt_q                      external counter value
//   cnt_en/cnt_clr             external counter enable / synchronous clear (combinational)
//   tc_pulse                   terminal count reached this cycle
//   busy/done/reps_left/state  status
module counter_sequencer #(
    parameter int WIDTH = 4,
    parameter int REP_W = 4
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [WIDTH-1:0] cfg_term,
    input  logic [REP_W-1:0] cfg_reps,
    input  logic             cfg_auto,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic             tc_pulse,
    output logic             busy,
    output logic             done,
    output logic [REP_W-1:0] reps_left,
    output logic [1:0]       state
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HOLD = 2'b10, DONE = 2'b11} state_t;
    state_t cur, nxt;
    logic [WIDTH-1:0] term_r;
    logic [REP_W-1:0] reps_r, reps_nxt, cfg_reps_m;
    logic auto_r, acc, tc, last, en_c, clr_c;
    // a zero repeat count still runs one period
    assign cfg_reps_m = (cfg_reps == '0) ? REP_W'(1) : cfg_reps;
    assign acc  = (cur == IDLE || cur == DONE) && start && !stop;
    assign tc   = (cur == RUN) && (cnt_q == term_r) && !pause && !stop;
    assign last = reps_left <= REP_W'(1);
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            cur       <= IDLE;
            term_r    <= '0;
            reps_r    <= '0;
            auto_r    <= 1'b0;
            reps_left <= '0;
        end else begin
            cur       <= nxt;
            reps_left <= reps_nxt;
            if (acc) begin
                term_r <= cfg_term;
                reps_r <= cfg_reps_m;
                auto_r <= cfg_auto;
            end
        end
    end
    always_comb begin
        nxt      = cur;
        reps_nxt = reps_left;
        en_c     = 1'b0;
        clr_c    = 1'b0;
        if (stop) begin
            nxt      = IDLE;
            reps_nxt = '0;
            clr_c    = 1'b1;
        end else if (acc) begin
            nxt      = RUN;
            reps_nxt = cfg_reps_m;
            clr_c    = 1'b1;
        end else if (cur == RUN) begin
            if (pause) begin
                nxt = HOLD;
            end else if (tc) begin
                if (!last) begin
                    clr_c    = 1'b1;
                    reps_nxt = reps_left - REP_W'(1);
                end else if (auto_r) begin
                    clr_c    = 1'b1;
                    reps_nxt = reps_r;
                end else begin
                    // one-shot finish: counter is left holding term_r
                    nxt      = DONE;
                    reps_nxt = '0;
                end
            end else begin
                en_c = 1'b1;
            end
        end else if (cur == HOLD && !pause) begin
            nxt = RUN;
        end
    end
    // combinational controls are forced low while reset is asserted
    assign cnt_en   = rst && en_c;
    assign cnt_clr  = rst && clr_c;
    assign tc_pulse = rst && tc;
    assign busy     = (cur == RUN) || (cur == HOLD);
    assign done     = (cur == DONE);
    assign state    = cur;
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: scoreboard bench driving counter_sequencer with a behavioural external counter.
module tb_counter_sequencer;
    localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_HOLD = 2'b10, S_DONE = 2'b11;
    logic clock = 1'b0, rst = 1'b0;
    logic start = 1'b0, stop = 1'b0, pause = 1'b0, cfg_auto = 1'b0;
    logic [3:0] cfg_term = '0, cfg_reps = '0, cnt_q, reps_left;
    logic cnt_en, cnt_clr, tc_pulse, busy, done;
    logic [1:0] state;
    int errors = 0, checks = 0;
    typedef struct {
        string tag;
        logic [1:0] st;
        logic [3:0] q;
        logic en, clr, tc;
        logic [3:0] rl;
    } exp_t;
    exp_t sb[$];

    counter_sequencer dut (
        .clock(clock), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .cfg_term(cfg_term), .cfg_reps(cfg_reps), .cfg_auto(cfg_auto), .cnt_q(cnt_q),
        .cnt_en(cnt_en), .cnt_clr(cnt_clr), .tc_pulse(tc_pulse), .busy(busy),
        .done(done), .reps_left(reps_left), .state(state)
    );

    always #5 clock = ~clock;

    always @(posedge clock or negedge rst)
        if (!rst) cnt_q <= '0;
        else if (cnt_clr) cnt_q <= '0;
        else if (cnt_en) cnt_q <= cnt_q + 4'd1;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, ".state"}, 8'(state), 8'(e.st));
            check({e.tag, ".cnt_q"}, 8'(cnt_q), 8'(e.q));
            check({e.tag, ".cnt_en"}, 8'(cnt_en), 8'(e.en));
            check({e.tag, ".cnt_clr"}, 8'(cnt_clr), 8'(e.clr));
            check({e.tag, ".tc_pulse"}, 8'(tc_pulse), 8'(e.tc));
            check({e.tag, ".reps_left"}, 8'(reps_left), 8'(e.rl));
            check({e.tag, ".busy"}, 8'(busy), 8'(e.st == S_RUN || e.st == S_HOLD));
            check({e.tag, ".done"}, 8'(done), 8'(e.st == S_DONE));
        end
    end

    task automatic cyc(input logic s, input logic t, input logic p, input string tag,
                       input logic [1:0] est, input logic [3:0] eq, input logic een,
                       input logic eclr, input logic etc, input logic [3:0] erl);
        exp_t e;
        start = s;
        stop  = t;
        pause = p;
        e = '{tag, est, eq, een, eclr, etc, erl};
        sb.push_back(e);
        @(negedge clock);
        @(posedge clock);
        #1;
    endtask

    task automatic cfg(input logic [3:0] term, input logic [3:0] reps, input logic au);
        cfg_term = term;
        cfg_reps = reps;
        cfg_auto = au;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("rst_state", 8'(state), 8'(S_IDLE));
        check("rst_en", 8'(cnt_en), 8'd0);
        rst = 1'b1;
        cyc(0, 0, 0, "idle", S_IDLE, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, "idle2", S_IDLE, 0, 0, 0, 0, 0);
        // one-shot term=3 reps=2
        cfg(4'd3, 4'd2, 1'b0);
        cyc(1, 0, 0, "os_acc", S_IDLE, 0, 0, 1, 0, 0);
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++)
                cyc(0, 0, 0, "os_run", S_RUN, 4'(k), k != 3, k == 3 && i == 0, k == 3, 4'(2 - i));
        cyc(0, 0, 0, "os_done", S_DONE, 3, 0, 0, 0, 0);
        cyc(0, 0, 0, "os_hold", S_DONE, 3, 0, 0, 0, 0);
        cyc(1, 1, 1, "pri_done", S_DONE, 3, 0, 1, 0, 0);
        cyc(0, 0, 0, "pri_idle", S_IDLE, 0, 0, 0, 0, 0);
        // auto-reload term=1 reps=1
        cfg(4'd1, 4'd1, 1'b1);
        cyc(1, 0, 0, "ar_acc", S_IDLE, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) cfg(4'd5, 4'd3, 1'b0);
            cyc(i == 2, 0, 0, "ar_p0", S_RUN, 0, 1, 0, 0, 1);
            cyc(0, 0, 0, "ar_p1", S_RUN, 1, 0, 1, 1, 1);
        end
        cyc(0, 1, 0, "ar_stop", S_RUN, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, "ar_idle", S_IDLE, 0, 0, 0, 0, 0);
        // pause term=5 reps=1
        cfg(4'd5, 4'd1, 1'b0);
        cyc(1, 0, 0, "pz_acc", S_IDLE, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, "pz_r0", S_RUN, 0, 1, 0, 0, 1);
        cyc(0, 0, 0, "pz_r1", S_RUN, 1, 1, 0, 0, 1);
        cyc(0, 0, 1, "pz_p0", S_RUN, 2, 0, 0, 0, 1);
        cyc(0, 0, 1, "pz_h1", S_HOLD, 2, 0, 0, 0, 1);
        cyc(0, 0, 1, "pz_h2", S_HOLD, 2, 0, 0, 0, 1);
        cyc(0, 0, 0, "pz_rel", S_HOLD, 2, 0, 0, 0, 1);
        cyc(1, 0, 0, "pz_r2", S_RUN, 2, 1, 0, 0, 1);
        cyc(0, 0, 0, "pz_r3", S_RUN, 3, 1, 0, 0, 1);
        cyc(0, 0, 0, "pz_r4", S_RUN, 4, 1, 0, 0, 1);
        cyc(0, 0, 0, "pz_tc", S_RUN, 5, 0, 0, 1, 1);
        cyc(0, 0, 0, "pz_done", S_DONE, 5, 0, 0, 0, 0);
        // edge config term=0 reps=0, started from DONE
        cfg(4'd0, 4'd0, 1'b0);
        cyc(1, 0, 0, "e_acc", S_DONE, 5, 0, 1, 0, 0);
        cyc(0, 0, 0, "e_tc", S_RUN, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, "e_done", S_DONE, 0, 0, 0, 0, 0);
        cfg(4'd2, 4'd1, 1'b0);
        cyc(1, 0, 0, "re_acc", S_DONE, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, "re_r0", S_RUN, 0, 1, 0, 0, 1);
        cyc(0, 0, 0, "re_r1", S_RUN, 1, 1, 0, 0, 1);
        cyc(0, 0, 0, "re_tc", S_RUN, 2, 0, 0, 1, 1);
        cyc(0, 0, 0, "re_done", S_DONE, 2, 0, 0, 0, 0);
        // reset in the middle of a run
        cfg(4'd7, 4'd1, 1'b0);
        cyc(1, 0, 0, "mr_acc", S_DONE, 2, 0, 1, 0, 0);
        cyc(0, 0, 0, "mr_r0", S_RUN, 0, 1, 0, 0, 1);
        cyc(0, 0, 0, "mr_r1", S_RUN, 1, 1, 0, 0, 1);
        rst = 1'b0;
        #1;
        check("mr_state", 8'(state), 8'(S_IDLE));
        check("mr_busy", 8'(busy), 8'd0);
        check("mr_done", 8'(done), 8'd0);
        check("mr_en", 8'(cnt_en), 8'd0);
        check("mr_clr", 8'(cnt_clr), 8'd0);
        check("mr_tc", 8'(tc_pulse), 8'd0);
        check("mr_reps", 8'(reps_left), 8'd0);
        @(posedge clock);
        #1;
        rst = 1'b1;
        cyc(0, 0, 0, "mr_idle", S_IDLE, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, "mr_idle2", S_IDLE, 0, 0, 0, 0, 0);
        @(negedge clock);
        check("sb_drain", 8'(sb.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Run-control FSM for a WIDTH-bit synchronous up-counter datapath, such as the JK-flip-flop ripple-free counter chain.
- The block drives the counter's enable and synchronous clear, and reads its count back.
- It detects a programmed terminal count and sequences a programmed number of periods.
- Periods run one-shot or auto-reload, with start, stop and pause control.
- The counter itself is external; this block owns only control and bookkeeping.

Parameters:
WIDTH, 4, counter width and terminal-count width
REP_W, 4, width of the period-repeat count

Ports:
clock  in  1  single clock; all state changes on the posedge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
start  in  1  start request, sampled each cycle
stop  in  1  abort request, sampled each cycle
pause  in  1  hold request, level sensitive
cfg_term  in  WIDTH  terminal count value, latched on start accept
cfg_reps  in  REP_W  periods per run, latched on start accept (0 treated as 1)
cfg_auto  in  1  1 = auto-reload after final period, latched on start accept
cnt_q  in  WIDTH  current value of the external counter
cnt_en  out  1  counter increment enable (combinational)
cnt_clr  out  1  counter synchronous clear (combinational, wins over cnt_en in the datapath)
tc_pulse  out  1  terminal count reached this cycle (combinational)
busy  out  1  state is RUN or HOLD
done  out  1  state is DONE
reps_left  out  REP_W  periods remaining, including the current one
state  out  2  IDLE=00, RUN=01, HOLD=10, DONE=11

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE immediately; term_r, reps_r, auto_r and reps_left go to 0.
  - All outputs are 0, including the combinational cnt_en, cnt_clr and tc_pulse, which are gated by reset.
  - Reset mid-run abandons the run; no done is produced.
- Event priority each cycle: stop > start > pause > terminal.
- stop (any state):
  - Next state is IDLE; cnt_clr=1 this cycle; cnt_en=0; tc_pulse=0.
  - reps_left is cleared to 0.
- start accept (state IDLE or DONE, stop=0):
  - Latch cfg_term, cfg_auto, and cfg_reps (0 mapped to 1) into term_r, auto_r, reps_r.
  - reps_left <= reps_r value; cnt_clr=1 this cycle; next state is RUN.
- start while RUN or HOLD is ignored; there is no restart.
- Terminal condition: tc = (state==RUN) and (cnt_q==term_r) and not pause and not stop.
- RUN, no terminal, no pause: cnt_en=1, cnt_clr=0.
- RUN at terminal: tc_pulse=1, cnt_en=0, and the outcome depends on reps_left:
  - reps_left>1: cnt_clr=1, reps_left decrements, stay in RUN.
  - reps_left==1 and auto_r=1: cnt_clr=1, reps_left reloads to reps_r, stay in RUN.
  - reps_left==1 and auto_r=0: cnt_clr=0, reps_left <= 0, next state is DONE; the counter holds at term_r.
- RUN with pause=1: cnt_en=0, no terminal evaluation, next state is HOLD.
- HOLD:
  - cnt_en=0, cnt_clr=0, counter frozen.
  - pause=0 returns to RUN next cycle, with counting resuming from the frozen value.
  - stop goes to IDLE.
- DONE: done=1, counter outputs idle; only start or stop leaves DONE.
- IDLE: all control outputs 0.
- Period length: term_r+1 RUN cycles, with cnt_q visiting 0..term_r.
  - A full one-shot run is reps_r*(term_r+1) RUN cycles, preceded by one accept cycle.
- term_r=0: every RUN cycle is terminal, giving a period of 1 cycle.
- cnt_q is assumed to increment by exactly 1 when enabled.
  - If cnt_q>term_r (external corruption), the sequencer keeps enabling and wraps through 2^WIDTH until equality.
  - This is documented behaviour, not an error state.

Test Plan:
- Reset: rst=0 during RUN -> state=00, busy=0, cnt_en=cnt_clr=tc_pulse=0 without waiting for a clock edge; after rst=1, IDLE holds until start.
- One-shot (term=3, reps=2, auto=0, start at T0):
  - T0: cnt_clr=1.
  - T1..T8: cnt_q=0,1,2,3,0,1,2,3.
  - tc_pulse at T4 and T8; reps_left goes 2->1 at T5 and 0 at T9; done=1 from T9 with cnt_q holding 3.
- Auto-reload (term=1, reps=1, auto=1):
  - tc_pulse every 2nd RUN cycle indefinitely; done stays 0.
  - reps_left stays 1; stop then gives IDLE with cnt_clr=1 for one cycle.
- Pause (term=5, reps=1):
  - pause held 3 cycles when cnt_q=2 -> state=HOLD, cnt_q stays 2.
  - On release, RUN resumes 3,4,5; tc_pulse once; then DONE.
- Priority: start, stop and pause all asserted in DONE -> IDLE, cnt_clr=1; start in RUN ignored (reps_left unchanged).
- Edge configuration (term=0, reps=0, auto=0):
  - Accept maps reps to 1; one RUN cycle with tc_pulse=1.
  - DONE next cycle; start in DONE restarts with newly latched config.
